// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types and helpers (state enum, bit_reverse)
package fft_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } fft_deser_state_t;

   // Reverse the low `width` bits of value; bits above width come back zero.
   function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
      logic [31:0] result;
      result = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            result[i] = value[width - 1 - i];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_deserializer.sv
// rtl/fft_deserializer.sv - serial-to-parallel frame assembler feeding the first FFT stage (option: FFT_DESERIALIZER_BITREV_EN)
module fft_deserializer #(
   parameter int BIT_WIDTH = 32,
   parameter int SIZE_FFT  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_real      [SIZE_FFT-1:0],
   output logic [BIT_WIDTH-1:0] send_imaginary [SIZE_FFT-1:0],
   output logic                 send_val,
   input  logic                 send_rdy
);
   import fft_pkg::*;

   localparam int               CNT_W    = $clog2(SIZE_FFT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE_FFT - 1);

   fft_deser_state_t     r_state;
   fft_deser_state_t     w_state_next;
   logic [CNT_W-1:0]     r_count;
   logic [CNT_W-1:0]     w_dest;
   logic                 w_accept;
   logic [BIT_WIDTH-1:0] r_lane [SIZE_FFT-1:0];

   // Lane that the current sample lands in: natural or bit-reversed order
`ifdef FFT_DESERIALIZER_BITREV_EN
   assign w_dest = CNT_W'(bit_reverse(32'(r_count), CNT_W));
`else
   assign w_dest = r_count;
`endif

   assign w_accept = recv_val && recv_rdy;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and handshake outputs, decoded from state only (plus reset gating)
   always_comb begin
      w_state_next = r_state;
      recv_rdy     = 1'b0;
      send_val     = 1'b0;
      case (r_state)
         COLLECT: begin
            recv_rdy = !reset;
            if (recv_val && (r_count == CNT_LAST)) begin
               w_state_next = FULL;
            end
         end
         FULL: begin
            send_val = 1'b1;
            if (send_rdy) begin
               w_state_next = COLLECT;
            end
         end
         default: w_state_next = COLLECT;
      endcase
   end

   // Sample counter: advances only on an accepted sample, wraps at the frame end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_accept) begin
         if (r_count == CNT_LAST) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Lane registers: single buffer, stale values survive until overwritten
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SIZE_FFT; k++) begin
            r_lane[k] <= '0;
         end
      end else if (w_accept) begin
         r_lane[w_dest] <= recv_msg;
      end
   end

   assign send_real = r_lane;

   // Real-valued input: imaginary lanes are tied to zero
   always_comb begin
      for (int k = 0; k < SIZE_FFT; k++) begin
         send_imaginary[k] = '0;
      end
   end

endmodule

// File: tb/tb_fft_deserializer.sv
// tb/tb_fft_deserializer.sv - scoreboard bench for fft_deserializer with a frame-level reference model
module tb_fft_deserializer;

   localparam int BW = 32;
   localparam int N  = 8;

   typedef logic [BW-1:0] frame_t [N];

   logic          clk;
   logic          reset;
   logic [BW-1:0] recv_msg;
   logic          recv_val;
   logic          recv_rdy;
   logic [BW-1:0] send_real      [N-1:0];
   logic [BW-1:0] send_imaginary [N-1:0];
   logic          send_val;
   logic          send_rdy;

   fft_deserializer #(.BIT_WIDTH(BW), .SIZE_FFT(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .recv_msg       (recv_msg),
      .recv_val       (recv_val),
      .recv_rdy       (recv_rdy),
      .send_real      (send_real),
      .send_imaginary (send_imaginary),
      .send_val       (send_val),
      .send_rdy       (send_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int       checks = 0;
   int       errors = 0;
   int       frames_issued = 0;
   int       frames_seen = 0;
   bit       rand_rdy = 1'b0;

   // reference model state
   logic [BW-1:0] coll[$];
   frame_t        exp_q[$];
   bit            m_full = 1'b0;
   bit            m_accepted = 1'b0;

   function automatic int dest_of(input int k);
      int r;
`ifdef FFT_DESERIALIZER_BITREV_EN
      r = 0;
      for (int b = 0; b < 3; b++) r += ((k >> b) & 1) << (2 - b);
`else
      r = k;
`endif
      return r;
   endfunction

   // Frame-level model: a frame is the next 8 accepted samples; one frame held at a time
   always @(posedge clk) begin
      m_accepted = 1'b0;
      if (reset) begin
         coll.delete();
         exp_q.delete();
         m_full = 1'b0;
      end else if (!m_full) begin
         if (recv_val) begin
            coll.push_back(recv_msg);
            m_accepted = 1'b1;
            if (coll.size() == N) begin
               frame_t f;
               for (int k = 0; k < N; k++) f[dest_of(k)] = coll[k];
               exp_q.push_back(f);
               coll.delete();
               m_full = 1'b1;
               frames_issued++;
            end
         end
      end else if (send_rdy) begin
         m_full = 1'b0;
      end
   end

   // Monitor: checks handshake outputs every cycle and the frame whenever send_val is up
   initial begin
      forever begin
         @(negedge clk);
         #1;
         checks++;
         if (recv_rdy !== (!m_full && !reset)) begin
            errors++;
            $display("FAIL recv_rdy got %b want %b t=%0t", recv_rdy, (!m_full && !reset), $time);
         end
         checks++;
         if (send_val !== m_full) begin
            errors++;
            $display("FAIL send_val got %b want %b t=%0t", send_val, m_full, $time);
         end
         begin
            logic [BW-1:0] acc;
            acc = '0;
            for (int k = 0; k < N; k++) acc |= send_imaginary[k];
            checks++;
            if (acc !== '0) begin
               errors++;
               $display("FAIL imaginary got %h want 0", acc);
            end
         end
         if (send_val === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame got send_val=1 want no frame pending");
            end else begin
               frame_t f;
               f = exp_q[0];
               for (int k = 0; k < N; k++) begin
                  checks++;
                  if (send_real[k] !== f[k]) begin
                     errors++;
                     $display("FAIL lane%0d got %h want %h t=%0t", k, send_real[k], f[k], $time);
                  end
               end
               if (send_rdy === 1'b1) begin
                  void'(exp_q.pop_front());
                  frames_seen++;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         recv_val = 1'b0;
         recv_msg = $urandom;
         if (rand_rdy) send_rdy = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic push_sample(input logic [BW-1:0] d, input int idles);
      int tries;
      idle(idles);
      tries = 0;
      forever begin
         @(negedge clk);
         recv_val = 1'b1;
         recv_msg = d;
         if (rand_rdy) send_rdy = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (m_accepted) break;
         tries++;
         if (tries > 64) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got no accept want accept of %h", d);
            break;
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      recv_val = 1'b0;
      recv_msg = '0;
      send_rdy = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #2;
      for (int k = 0; k < N; k++) begin
         checks++;
         if (send_real[k] !== '0) begin
            errors++;
            $display("FAIL reset_lane%0d got %h want 0", k, send_real[k]);
         end
      end

      // basic frame, back-to-back, downstream always ready
      for (int k = 0; k < N; k++) push_sample(BW'((k + 1) << 16), 0);
      idle(2);

      // backpressure: frame held 5 cycles while 0xDEAD is offered
      @(negedge clk);
      send_rdy = 1'b0;
      recv_val = 1'b0;
      for (int k = 0; k < N; k++) push_sample(BW'($urandom), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         recv_val = 1'b1;
         recv_msg = 32'h0000_DEAD;
      end
      @(negedge clk);
      recv_val = 1'b0;
      send_rdy = 1'b1;
      for (int k = 0; k < N; k++) push_sample(BW'(32'h100 + k), 0);
      idle(2);

      // bubbles: 1,0,0,1,0,0,...
      for (int k = 0; k < N; k++) push_sample(BW'($urandom), (k == 0) ? 0 : 2);
      idle(2);

      // reset mid-frame discards the partial frame
      for (int k = 0; k < 3; k++) push_sample(BW'(32'hAA00 + k), 0);
      @(negedge clk);
      recv_val = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < N; k++) push_sample(BW'(32'h10 + k), 0);
      idle(2);

      // three back-to-back frames
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < N; k++) push_sample(BW'((f << 8) | k), 0);
      idle(2);

      // lane-order frame 0..7
      for (int k = 0; k < N; k++) push_sample(BW'(k), 0);
      idle(2);

      // randomized gaps and downstream readiness
      rand_rdy = 1'b1;
      for (int f = 0; f < 6; f++)
         for (int k = 0; k < N; k++) push_sample(BW'($urandom), $urandom_range(0, 2));
      rand_rdy = 1'b0;
      @(negedge clk);
      send_rdy = 1'b1;
      recv_val = 1'b0;
      idle(4);

      checks++;
      if (frames_seen != frames_issued || exp_q.size() != 0) begin
         errors++;
         $display("FAIL frame_count got %0d seen want %0d issued (pending %0d)",
                  frames_seen, frames_issued, exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
